piso_tx: RTL and testbench

- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first, one bit per clock, on a serial line.
- Sits directly upstream of the serial-in/parallel-out shift register. sd drives that register's d input. After a frame is shifted in, its q4..q1 hold the word as d[3:0].
- Updates on the same clock edge as the downstream stage, so a gapless stream of words can be delivered.

---
 rtl/piso_tx.sv | 92 +++++++++
 tb/tb_piso_tx.sv | 96 +++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: MSB-first parallel-in/serial-out transmitter with valid/ready load, negedge-clocked; define PISO_TX_PARITY_EN to append an even-parity bit.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sd,
  output logic             sen,
  output logic             frame_done
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sd_n, sen_n, fd_n, accept, last;
`ifdef PISO_TX_PARITY_EN
  logic             par;
  assign last = state == PARITY;
`else
  assign last = state == SHIFT && cnt == '0;
`endif
  assign load_ready = state == IDLE || last;
  assign accept     = load_valid & load_ready;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    sd_n    = sd;
    sen_n   = sen;
    fd_n    = frame_done;
    if (accept) begin
      state_n = SHIFT;
      shreg_n = load_data;
      sd_n    = load_data[WIDTH-1];
      sen_n   = 1'b1;
      cnt_n   = CW'(WIDTH - 1);
      fd_n    = 1'b0;
    end else if (last) begin
      state_n = IDLE;
      sd_n    = 1'b0;
      sen_n   = 1'b0;
      fd_n    = 1'b0;
    end else if (state == SHIFT && cnt != '0) begin
      shreg_n = shreg << 1;
      sd_n    = shreg[WIDTH-2];
      cnt_n   = cnt - CW'(1);
`ifdef PISO_TX_PARITY_EN
      fd_n    = 1'b0;
`else
      fd_n    = cnt == CW'(1);
`endif
    end
`ifdef PISO_TX_PARITY_EN
    else if (state == SHIFT) begin
      state_n = PARITY;
      sd_n    = par;
      fd_n    = 1'b1;
    end
`endif
  end
  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sd         <= 1'b0;
      sen        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      sd         <= sd_n;
      sen        <= sen_n;
      frame_done <= fd_n;
    end
  end
`ifdef PISO_TX_PARITY_EN
  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else if (accept) par <= ^load_data;
  end
`endif
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: randomized and directed checks of piso_tx against a bit-queue reference model and a downstream negedge shift register.
module tb_piso_tx;
  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic         ck = 1'b1;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, sd, sen, frame_done;
  logic [W+P-1:0] dq = '0;
  logic         mq[$];
  int           n_vec = 0;
  int           n_err = 0;
  piso_tx #(.WIDTH(W)) dut (
    .ck(ck), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .sd(sd), .sen(sen), .frame_done(frame_done)
  );
  always #5 ck = ~ck;
  always @(negedge ck) dq <= {dq[W+P-2:0], sd};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_outs();
    chk("sd", 32'(sd), 32'(mq.size() != 0 ? mq[0] : 1'b0));
    chk("sen", 32'(sen), 32'(mq.size() != 0));
    chk("frame_done", 32'(frame_done), 32'(mq.size() == 1));
    chk("load_ready", 32'(load_ready), 32'(mq.size() <= 1));
  endtask
  task automatic step(input logic v, input logic [W-1:0] d);
    logic acc;
    load_valid = v;
    load_data  = d;
    acc = v && mq.size() <= 1;
    @(negedge ck);
    if (acc) begin
      mq = {};
      for (int i = W - 1; i >= 0; i--) mq.push_back(d[i]);
      if (P != 0) mq.push_back(^d);
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
    end
    @(posedge ck);
    chk_outs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
  endtask
  initial begin
    #2;
    chk("reset_outs", {28'd0, sd, sen, frame_done, load_ready}, 32'b0001);
    @(posedge ck);
    rst_n = 1'b1;
    step(1'b1, 4'b1011);
    idle(W + P + 1);
    step(1'b1, 4'b1011);
    idle(W + P - 1);
    step(1'b1, 4'b0110);
    idle(W + P + 1);
    step(1'b1, 4'b0001);
    for (int i = 0; i < W + P; i++) step(1'b1, 4'b1111);
    idle(W + P + 1);
    step(1'b1, 4'b1010);
    idle(1);
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    mq = {};
    chk("midreset_outs", {28'd0, sd, sen, frame_done, load_ready}, 32'b0001);
    @(posedge ck);
    rst_n = 1'b1;
    chk_outs();
    idle(2);
    step(1'b1, 4'b1101);
    idle(W + P);
    chk("chain_q", 32'(dq[W+P-1:P]), 32'b1101);
    if (P != 0) chk("chain_par", 32'(dq[0]), 32'(1'b1));
    idle(1);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), W'($urandom));
    idle(W + P + 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
